// File: rtl/div5_pkg.sv
// Shared definitions for the divisible-by-5 word sequencer.
// Purpose : state encoding, remainder width and modulus, plus the single
//           remainder step used by the serial core.
// Contents: S_IDLE/S_SHIFT/S_DONE, REM_W, MOD, mod5_step().
package div5_pkg;

  localparam int REM_W = 3;
  localparam int MOD   = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // One MSB-first step: (2*rem + b) mod 5. With rem <= 4 the 4-bit sum is
  // at most 9, so a single conditional subtract fully reduces it.
  function automatic logic [REM_W-1:0] mod5_step(input logic [REM_W-1:0] rem,
                                                 input logic b);
    logic [3:0] t;
    t = {rem, b};
    if (t >= 4'(MOD)) t = t - 4'(MOD);
    return t[REM_W-1:0];
  endfunction

endpackage

// File: rtl/mod5_serial_core.sv
// Bit-serial remainder-mod-5 register with clear and enable.
// Purpose : holds the running remainder of the binary number shifted in so far.
// Ports   : clk    - rising-edge clock
//           reset  - synchronous active-low reset (remainder -> 0)
//           clr    - force remainder to 0 (takes priority over en)
//           en     - advance remainder by one bit
//           bit_in - next bit, MSB first
//           rem    - current remainder, always 0..4
module mod5_serial_core
  import div5_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [REM_W-1:0] rem
);

  logic [REM_W-1:0] r_rem;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rem <= '0;
    end else if (clr) begin
      r_rem <= '0;
    end else if (en) begin
      r_rem <= mod5_step(r_rem, bit_in);
    end
  end

  assign rem = r_rem;

endmodule

// File: rtl/div5_word_sequencer.sv
// Word-level sequencer around the serial mod-5 core.
// Purpose : accepts a WIDTH-bit word, shifts it MSB-first into the core over
//           WIDTH cycles, then offers the remainder and a divisible flag.
//           in_chain=1 continues the previous remainder (multi-word number).
// Ports   : clk, reset (sync, active-low)
//           in_valid/in_ready/in_data/in_chain - input word channel
//           out_valid/out_ready/out_rem/out_div5 - result channel
//           busy      - high while shifting
//           dbg_state - current FSM state (S_IDLE/S_SHIFT/S_DONE)
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. The producer holds its payload stable until that edge; ready may
// depend combinationally on the opposite side (in_ready uses out_ready so a
// result can be retired and the next word accepted on the same edge).
module div5_word_sequencer
  import div5_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REM_W-1:0] out_rem,
  output logic             out_div5,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;
  logic [REM_W-1:0] w_rem;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next_state = S_SHIFT;
      S_SHIFT: if (w_last) w_next_state = S_DONE;
      S_DONE: begin
        if (out_ready) w_next_state = in_valid ? S_SHIFT : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_SHIFT: busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Shift register and bit counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= in_data;
      r_cnt   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_shift <= r_shift << 1;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Accepting a non-chained word restarts the number from zero; a chained
  // word leaves the remainder untouched so the new bits extend it.
  mod5_serial_core u_core (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_accept & ~in_chain),
    .en     (r_state == S_SHIFT),
    .bit_in (r_shift[WIDTH-1]),
    .rem    (w_rem)
  );

  assign out_rem   = w_rem;
  assign out_div5  = (w_rem == '0);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_div5_word_sequencer.sv
module tb_div5_word_sequencer;

  localparam int WIDTH = 8;

  // ---------------- clock / reset ----------------
  logic             clk       = 1'b0;
  logic             reset     = 1'b0;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             in_chain  = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [2:0]       out_rem;
  logic             out_div5;
  logic             busy;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  div5_word_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_chain  (in_chain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rem   (out_rem),
    .out_div5  (out_div5),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];   // {div5, rem}
  int         model_rem = 0;
  int         n_checks  = 0;
  int         n_fail    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end #1 after a rising edge.
  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
    model_rem = 0;
    exp_q.delete();
  endtask

  // Present a word and wait (bounded) until in_ready; the accept edge is the
  // next rising edge. The expected result is queued here.
  task automatic offer(input logic [WIDTH-1:0] d, input logic ch);
    int n;
    logic [2:0] r;
    in_valid = 1'b1;
    in_data  = d;
    in_chain = ch;
    n = 0;
    while (!in_ready && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("in_ready_wait", in_ready, 1);
    model_rem = ((ch ? model_rem : 0) * (1 << WIDTH) + int'(d)) % 5;
    r = 3'(model_rem);
    exp_q.push_back({(model_rem == 0), r});
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic ch);
    offer(d, ch);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called one step after the accept edge: counts edges until out_valid and
  // the number of cycles busy was seen high.
  task automatic wait_out(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!out_valid && lat < 64) begin
      if (busy) busy_n++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_rem"}, out_rem, e[2:0]);
      check_eq({tag, "_div5"}, out_div5, e[3]);
    end
  endtask

  // Full single-word transaction with out_ready high.
  task automatic run_word(input string tag, input logic [WIDTH-1:0] d, input logic ch);
    int lat, bn;
    send(d, ch);
    wait_out(lat, bn);
    check_eq({tag, "_latency"}, lat, WIDTH);
    check_eq({tag, "_busy_cycles"}, bn, WIDTH);
    check_eq({tag, "_out_valid"}, out_valid, 1);
    check_result(tag);
    @(posedge clk);
    #1;
    check_eq({tag, "_retired"}, out_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, bn, seen;

    // 1. reset
    do_reset(2);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_rem", out_rem, 0);
    check_eq("rst_out_div5", out_div5, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", dbg_state, 0);

    out_ready = 1'b1;

    // 2. 25 is divisible by 5
    run_word("w25", 8'd25, 1'b0);

    // 3. plain words
    run_word("w7", 8'd7, 1'b0);
    run_word("w255", 8'd255, 1'b0);

    // 4. chained stream 0x01_00_04 = 65540
    run_word("c01", 8'h01, 1'b0);
    run_word("c00", 8'h00, 1'b1);
    run_word("c04", 8'h04, 1'b1);

    // random words, random chaining
    for (int i = 0; i < 12; i++) begin
      run_word("rnd", WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), 1'($urandom_range(0, 1)));
    end

    // 5. backpressure, then same-edge retire + accept
    out_ready = 1'b0;
    send(8'd13, 1'b0);
    wait_out(lat, bn);
    check_eq("bp_latency", lat, WIDTH);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_out_rem", out_rem, 3);
      check_eq("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    check_result("bp");
    out_ready = 1'b1;
    offer(8'd20, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("b2b_busy", busy, 1);
    check_eq("b2b_out_valid", out_valid, 0);
    check_eq("b2b_state", dbg_state, 1);
    wait_out(lat, bn);
    check_eq("b2b_latency", lat, WIDTH);
    check_result("b2b");
    @(posedge clk);
    #1;

    // 6. reset during the 4th shift cycle
    send(8'd25, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_eq("mid_busy", busy, 1);
    do_reset(1);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_state", dbg_state, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_rem", out_rem, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    check_eq("mid_rst_no_output", seen, 0);
    run_word("post_rst_chain", 8'd10, 1'b1);

    // 6b. reset while a result (rem 2) waits in DONE clears the chain remainder
    send(8'd7, 1'b0);
    wait_out(lat, bn);
    check_result("pre_done_rst");
    do_reset(1);
    check_eq("done_rst_out_valid", out_valid, 0);
    check_eq("done_rst_rem", out_rem, 0);
    run_word("done_rst_chain", 8'd10, 1'b1);

    // ---------------- report ----------------
    check_eq("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div5_word_sequencer.md
Name: div5_word_sequencer

Overview:
Controller that sequences a bit-serial divisible-by-5 remainder engine over parallel input words. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it MSB-first, one bit per cycle, into the remainder engine. It then presents the remainder and a divisible flag through a second valid/ready handshake. An optional chain mode continues the remainder across words, so a multi-word stream is treated as one long binary number.

Parameters:
WIDTH, 8, bits per input word (legal 1..32)
CNT_W, $clog2(WIDTH+1), width of internal bit counter (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
in_valid  input  1  input word offered
in_ready  output  1  sequencer can accept a word this cycle
in_data  input  WIDTH  word to test, shifted MSB first
in_chain  input  1  sampled with in_data; 1 = continue from previous remainder, 0 = start from 0
out_valid  output  1  result available
out_ready  input  1  consumer takes result this cycle
out_rem  output  3  remainder mod 5 of the number processed so far (0..4)
out_div5  output  1  1 when out_rem == 0
busy  output  1  high in SHIFT state

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset (reset==0 at a clk edge): state IDLE, remainder 0, counter 0, shift reg 0. Outputs after reset: in_ready=1, out_valid=0, out_rem=0, out_div5=1, busy=0.
- Reset mid-operation (SHIFT or DONE) aborts the word with no output. The pending result is discarded and the chain remainder clears to 0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from state and out_ready.
- Accept happens at an edge where in_valid & in_ready. On accept:
  - shift reg <= in_data, counter <= 0, state <= SHIFT.
  - remainder <= 0 if in_chain==0; otherwise it keeps its value.
- SHIFT, each cycle:
  - b = shift reg MSB.
  - remainder <= (2*remainder + b) mod 5, computed in 4 bits then reduced; the result is never 5..7.
  - Shift reg shifts left by 1; counter increments.
  - When counter reaches WIDTH-1 the state moves to DONE on that edge.
  - Exactly WIDTH SHIFT cycles occur.
- Latency: out_valid rises WIDTH cycles after the accept edge (first cycle in DONE).
- DONE:
  - out_valid=1. out_rem and out_div5 hold stable until the handshake; the remainder register is not modified.
  - On out_valid & out_ready:
    - If in_valid is also high, the new word is accepted on the same edge and the state goes to SHIFT (back-to-back; throughput WIDTH+1 cycles/word).
    - Otherwise the state goes to IDLE.
- IDLE: out_valid=0. out_rem and out_div5 keep the last result, which is visible but not valid.
- in_valid while busy is ignored (in_ready=0). Sources must hold in_data and in_chain until accepted.
- in_chain=1 on the first word after reset behaves as chain from 0.
- WIDTH=1: one SHIFT cycle, then DONE.
- The remainder arithmetic is the only datapath; no overflow is possible because the remainder is always <5.

Decomposition:
- Shared package/include (div5_pkg):
  - State encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
  - REM_W=3.
  - MOD=5.
- One sub-module, mod5_serial_core: the remainder register.
  - Inputs: clk, reset, clr, en, bit.
  - Output: rem[2:0].
  - This is the existing serial divisible-by-5 FSM behaviour with added clear and enable.
- div5_word_sequencer holds the handshake FSM, shift register and counter.

Test Plan:
1. Reset held low 2 cycles, then released. Require in_ready=1, out_valid=0, out_rem=0, busy=0.
2. WIDTH=8, in_data=8'd25, chain=0, out_ready=1. Require busy for 8 cycles, then out_valid=1 exactly 8 cycles after accept, out_rem=0, out_div5=1.
3. in_data=8'd7, chain=0 → out_rem=2, out_div5=0. Then in_data=8'd255 → out_rem=0, out_div5=1.
4. Chain: 8'h01 (chain=0) → out_rem=1. Then 8'h00 (chain=1) → out_rem=1 (256 mod 5). Then 8'h04 (chain=1) → out_rem=0 (65540 mod 5), out_div5=1.
5. Backpressure: out_ready=0 for 5 cycles in DONE. Require out_valid and out_rem stable, in_ready=0. Raise out_ready with in_valid=1 → same-edge accept, busy next cycle.
6. Reset low during the 4th SHIFT cycle of 8'd25. Require no out_valid, state IDLE. A following chain=1 word 8'd10 → out_rem=0.
